// File: rtl/c7bifu_ibuf.sv
// c7bifu_ibuf: instruction buffer between the I-cache return path and decode.
// Circular FIFO of DEPTH {inst, pc} entries. It tracks one in-flight fetch so
// that back-pressure leaves room for it, and it discards stale returns after a
// flush. A sticky overflow flag records data that arrived while the buffer was
// already full.
// Optional feature: define C7BIFU_IBUF_BYPASS_EN to forward returning data
// straight to decode while the buffer is empty.
module c7bifu_ibuf #(
  parameter int DEPTH = 4,
  parameter int IW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          icu_ifu_ack_ic1,
  input  logic          icu_ifu_data_valid_ic2,
  input  logic [IW-1:0] icu_ifu_inst_ic2,
  input  logic [IW-1:0] ifu_pc_ic2,
  input  logic          exu_ifu_except,
  input  logic          exu_ifu_stall,
  output logic          ifu_exu_valid_d,
  output logic [IW-1:0] ifu_exu_inst_d,
  output logic [IW-1:0] ifu_exu_pc_d,
  output logic          ifu_ibuf_full,
  output logic          ifu_ibuf_ovf
);

  localparam int              AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]     DEPTH_C  = (AW + 1)'(DEPTH);
  localparam logic [AW:0]     CNT_ZERO = {(AW + 1){1'b0}};
  localparam logic [AW:0]     CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0]   PTR_ONE  = AW'(1);
  localparam logic [AW+1:0]   FULL_THR = (AW + 2)'(DEPTH - 1);

  logic [IW-1:0] inst_mem_q [DEPTH];
  logic [IW-1:0] pc_mem_q   [DEPTH];

  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic          inflight_q, inflight_d;
  logic          drop_q, drop_d;
  logic          ovf_q, ovf_d;

  logic          push_try_s;
  logic          push_s;
  logic          pop_s;
  logic          byp_s;
  logic          ovf_hit_s;

  // Decide push/pop/bypass for this cycle and compute next pointer/count/flag state.
  always_comb begin
    count_d    = count_q;
    rptr_d     = rptr_q;
    wptr_d     = wptr_q;
    inflight_d = inflight_q;
    drop_d     = drop_q;
    ovf_d      = ovf_q;

    // Returning data is a candidate for the buffer unless it is stale or flushed.
    push_try_s = icu_ifu_data_valid_ic2 & ~drop_q & ~exu_ifu_except;
`ifdef C7BIFU_IBUF_BYPASS_EN
    byp_s      = push_try_s & (count_q == CNT_ZERO);
`else
    byp_s      = 1'b0;
`endif
    // A bypassed instruction that decode consumes at once never needs a slot.
    push_s     = push_try_s & (count_q != DEPTH_C) & ~(byp_s & ~exu_ifu_stall);
    ovf_hit_s  = push_try_s & (count_q == DEPTH_C);
    pop_s      = (count_q != CNT_ZERO) & ~exu_ifu_stall & ~exu_ifu_except;

    // Ack wins over a same-cycle return: the new request is now the one in flight.
    if (icu_ifu_ack_ic1) begin
      inflight_d = 1'b1;
    end else if (icu_ifu_data_valid_ic2) begin
      inflight_d = 1'b0;
    end else begin
      inflight_d = inflight_q;
    end

    if (ovf_hit_s) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_q;
    end

    if (exu_ifu_except) begin
      // Flush: empty the buffer and mark any request whose data is still to come.
      count_d = CNT_ZERO;
      rptr_d  = wptr_q;
      drop_d  = (inflight_q & ~icu_ifu_data_valid_ic2) | icu_ifu_ack_ic1;
    end else begin
      if (drop_q && icu_ifu_data_valid_ic2) begin
        drop_d = 1'b0;
      end else begin
        drop_d = drop_q;
      end
      if (push_s) begin
        wptr_d = wptr_q + PTR_ONE;
      end else begin
        wptr_d = wptr_q;
      end
      if (pop_s) begin
        rptr_d = rptr_q + PTR_ONE;
      end else begin
        rptr_d = rptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register; the data array is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q    <= CNT_ZERO;
      rptr_q     <= {AW{1'b0}};
      wptr_q     <= {AW{1'b0}};
      inflight_q <= 1'b0;
      drop_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      count_q    <= count_d;
      rptr_q     <= rptr_d;
      wptr_q     <= wptr_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      ovf_q      <= ovf_d;
    end
  end

  // Entry storage, written at the write pointer on an accepted push.
  always_ff @(posedge clk) begin
    if (push_s) begin
      inst_mem_q[wptr_q] <= icu_ifu_inst_ic2;
      pc_mem_q[wptr_q]   <= ifu_pc_ic2;
    end else begin
      inst_mem_q[wptr_q] <= inst_mem_q[wptr_q];
      pc_mem_q[wptr_q]   <= pc_mem_q[wptr_q];
    end
  end

  // Decode-side view: head entry, or the returning data when it is forwarded.
  always_comb begin
    if (byp_s) begin
      ifu_exu_valid_d = 1'b1;
      ifu_exu_inst_d  = icu_ifu_inst_ic2;
      ifu_exu_pc_d    = ifu_pc_ic2;
    end else begin
      ifu_exu_valid_d = (count_q != CNT_ZERO);
      ifu_exu_inst_d  = inst_mem_q[rptr_q];
      ifu_exu_pc_d    = pc_mem_q[rptr_q];
    end
  end

  // Back-pressure counts the in-flight request so its data always has a slot.
  always_comb begin
    ifu_ibuf_full = (({1'b0, count_q}) + {{(AW + 1){1'b0}}, inflight_q}) >= FULL_THR;
  end

  assign ifu_ibuf_ovf = ovf_q;

endmodule

// File: tb/tb_c7bifu_ibuf.sv
// Directed self-checking bench for c7bifu_ibuf (default build, DEPTH=4, IW=32).
module tb_c7bifu_ibuf;

  localparam int DEPTH = 4;
  localparam int IW    = 32;

  logic          clk;
  logic          reset;
  logic          icu_ifu_ack_ic1;
  logic          icu_ifu_data_valid_ic2;
  logic [IW-1:0] icu_ifu_inst_ic2;
  logic [IW-1:0] ifu_pc_ic2;
  logic          exu_ifu_except;
  logic          exu_ifu_stall;
  logic          ifu_exu_valid_d;
  logic [IW-1:0] ifu_exu_inst_d;
  logic [IW-1:0] ifu_exu_pc_d;
  logic          ifu_ibuf_full;
  logic          ifu_ibuf_ovf;

  int checks;
  int errors;

  c7bifu_ibuf #(.DEPTH(DEPTH), .IW(IW)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .icu_ifu_ack_ic1        (icu_ifu_ack_ic1),
    .icu_ifu_data_valid_ic2 (icu_ifu_data_valid_ic2),
    .icu_ifu_inst_ic2       (icu_ifu_inst_ic2),
    .ifu_pc_ic2             (ifu_pc_ic2),
    .exu_ifu_except         (exu_ifu_except),
    .exu_ifu_stall          (exu_ifu_stall),
    .ifu_exu_valid_d        (ifu_exu_valid_d),
    .ifu_exu_inst_d         (ifu_exu_inst_d),
    .ifu_exu_pc_d           (ifu_exu_pc_d),
    .ifu_ibuf_full          (ifu_ibuf_full),
    .ifu_ibuf_ovf           (ifu_ibuf_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    icu_ifu_ack_ic1        = 1'b0;
    icu_ifu_data_valid_ic2 = 1'b0;
    icu_ifu_inst_ic2       = 32'h0;
    ifu_pc_ic2             = 32'h0;
    exu_ifu_except         = 1'b0;
  endtask

  task automatic ret(input logic [31:0] inst, input logic [31:0] pc);
    icu_ifu_data_valid_ic2 = 1'b1;
    icu_ifu_inst_ic2       = inst;
    ifu_pc_ic2             = pc;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exu_ifu_stall = 1'b0;
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    chk("rst_valid", 32'(ifu_exu_valid_d), 32'd0);
    chk("rst_full", 32'(ifu_ibuf_full), 32'd0);
    chk("rst_ovf", 32'(ifu_ibuf_ovf), 32'd0);

    // Basic fetch: ack at cycle 1, data at cycle 3, visible at cycle 4, gone at 5
    icu_ifu_ack_ic1 = 1'b1;
    tick();
    idle();
    chk("t1_inflight", 32'(dut.inflight_q), 32'd1);
    tick();
    ret(32'h0000_0013, 32'h1C00_0000);
    chk("t1_valid_c3", 32'(ifu_exu_valid_d), 32'd0);
    tick();
    idle();
    chk("t1_valid_c4", 32'(ifu_exu_valid_d), 32'd1);
    chk("t1_inst_c4", ifu_exu_inst_d, 32'h0000_0013);
    chk("t1_pc_c4", ifu_exu_pc_d, 32'h1C00_0000);
    tick();
    chk("t1_valid_c5", 32'(ifu_exu_valid_d), 32'd0);

    // Stall held: fill until full, then drain in order
    exu_ifu_stall = 1'b1;
    icu_ifu_ack_ic1 = 1'b1;
    tick();
    idle();
    chk("t2_full_c0i1", 32'(ifu_ibuf_full), 32'd0);
    ret(32'hA0, 32'h100);
    tick();
    idle();
    icu_ifu_ack_ic1 = 1'b1;
    tick();
    idle();
    chk("t2_full_c1i1", 32'(ifu_ibuf_full), 32'd0);
    ret(32'hA1, 32'h104);
    tick();
    idle();
    chk("t2_full_c2i0", 32'(ifu_ibuf_full), 32'd0);
    icu_ifu_ack_ic1 = 1'b1;
    tick();
    idle();
    chk("t2_full_c2i1", 32'(ifu_ibuf_full), 32'd1);
    ret(32'hA2, 32'h108);
    tick();
    idle();
    chk("t2_count3", 32'(dut.count_q), 32'd3);
    chk("t2_full_c3i0", 32'(ifu_ibuf_full), 32'd1);
    chk("t2_head_held", ifu_exu_inst_d, 32'hA0);
    exu_ifu_stall = 1'b0;
    chk("t2_pop0_inst", ifu_exu_inst_d, 32'hA0);
    chk("t2_pop0_pc", ifu_exu_pc_d, 32'h100);
    tick();
    chk("t2_pop1_inst", ifu_exu_inst_d, 32'hA1);
    chk("t2_pop1_pc", ifu_exu_pc_d, 32'h104);
    tick();
    chk("t2_pop2_inst", ifu_exu_inst_d, 32'hA2);
    chk("t2_pop2_pc", ifu_exu_pc_d, 32'h108);
    tick();
    chk("t2_empty", 32'(ifu_exu_valid_d), 32'd0);

    // Flush with a fetch in flight: late data is dropped, next fetch is fine
    icu_ifu_ack_ic1 = 1'b1;
    tick();
    idle();
    exu_ifu_except = 1'b1;
    tick();
    idle();
    chk("t3_drop_set", 32'(dut.drop_q), 32'd1);
    tick();
    ret(32'hDEAD, 32'h200);
    tick();
    idle();
    chk("t3_valid_after_drop", 32'(ifu_exu_valid_d), 32'd0);
    chk("t3_drop_clr", 32'(dut.drop_q), 32'd0);
    chk("t3_count0", 32'(dut.count_q), 32'd0);
    icu_ifu_ack_ic1 = 1'b1;
    tick();
    idle();
    ret(32'hB0, 32'h204);
    tick();
    idle();
    chk("t3_next_valid", 32'(ifu_exu_valid_d), 32'd1);
    chk("t3_next_inst", ifu_exu_inst_d, 32'hB0);
    tick();
    chk("t3_next_popped", 32'(ifu_exu_valid_d), 32'd0);

    // Flush coinciding with returning data at count=2
    exu_ifu_stall = 1'b1;
    ret(32'hC0, 32'h300);
    tick();
    ret(32'hC1, 32'h304);
    tick();
    idle();
    chk("t4_count2", 32'(dut.count_q), 32'd2);
    icu_ifu_ack_ic1 = 1'b1;
    tick();
    idle();
    ret(32'hC2, 32'h308);
    exu_ifu_except = 1'b1;
    tick();
    idle();
    chk("t4_count0", 32'(dut.count_q), 32'd0);
    chk("t4_valid0", 32'(ifu_exu_valid_d), 32'd0);
    chk("t4_drop0", 32'(dut.drop_q), 32'd0);
    chk("t4_inflight0", 32'(dut.inflight_q), 32'd0);
    tick();
    chk("t4_still_empty", 32'(ifu_exu_valid_d), 32'd0);

    // Overflow: data forced into a full buffer
    for (int i = 0; i < DEPTH; i++) begin
      ret(32'hD0 + 32'(i), 32'h400 + 32'(4 * i));
      tick();
    end
    idle();
    chk("t5_count4", 32'(dut.count_q), 32'd4);
    chk("t5_full", 32'(ifu_ibuf_full), 32'd1);
    chk("t5_ovf_pre", 32'(ifu_ibuf_ovf), 32'd0);
    ret(32'hEE, 32'h4FC);
    tick();
    idle();
    chk("t5_ovf_set", 32'(ifu_ibuf_ovf), 32'd1);
    chk("t5_count_hold", 32'(dut.count_q), 32'd4);
    exu_ifu_stall = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      chk($sformatf("t5_drain%0d_inst", i), ifu_exu_inst_d, 32'hD0 + 32'(i));
      chk($sformatf("t5_drain%0d_pc", i), ifu_exu_pc_d, 32'h400 + 32'(4 * i));
      tick();
    end
    chk("t5_drained", 32'(ifu_exu_valid_d), 32'd0);
    chk("t5_ovf_sticky", 32'(ifu_ibuf_ovf), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_ovf_reset", 32'(ifu_ibuf_ovf), 32'd0);

    // Simultaneous push/pop at count=1 across the write-pointer wrap
    ret(32'hF0, 32'h500);
    tick();
    chk("t6_first", ifu_exu_inst_d, 32'hF0);
    for (int i = 1; i < 5; i++) begin
      ret(32'hF0 + 32'(i), 32'h500 + 32'(4 * i));
      tick();
      chk($sformatf("t6_step%0d_count", i), 32'(dut.count_q), 32'd1);
      chk($sformatf("t6_step%0d_inst", i), ifu_exu_inst_d, 32'hF0 + 32'(i));
      chk($sformatf("t6_step%0d_pc", i), ifu_exu_pc_d, 32'h500 + 32'(4 * i));
      if (i == 3) begin
        chk("t6_wptr_wrapped", 32'(dut.wptr_q), 32'd0);
      end else begin
        chk($sformatf("t6_step%0d_valid", i), 32'(ifu_exu_valid_d), 32'd1);
      end
    end
    idle();
    tick();
    chk("t6_empty", 32'(ifu_exu_valid_d), 32'd0);

    // Ack and data in the same cycle keep a fetch in flight; reset forgets it
    icu_ifu_ack_ic1 = 1'b1;
    ret(32'h77, 32'h600);
    tick();
    idle();
    chk("t7_inflight_both", 32'(dut.inflight_q), 32'd1);
    chk("t7_pushed", ifu_exu_inst_d, 32'h77);
    reset = 1'b1;
    icu_ifu_ack_ic1 = 1'b1;
    tick();
    reset = 1'b0;
    idle();
    chk("t7_inflight_rst", 32'(dut.inflight_q), 32'd0);
    chk("t7_valid_rst", 32'(ifu_exu_valid_d), 32'd0);
    chk("t7_full_rst", 32'(ifu_ibuf_full), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/c7bifu_ibuf.md
C7BIFU_IBUF -- requirements
Module: c7bifu_ibuf

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, number of instruction entries (power of two, 2..8).
REQ-002 The block SHALL have parameter IW, default 32, instruction and PC width.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port icu_ifu_ack_ic1  input  1  ICU accepted a fetch request; one fetch is now in flight.
REQ-006 The block SHALL have port icu_ifu_data_valid_ic2  input  1  fetch data returning this cycle.
REQ-007 The block SHALL have port icu_ifu_inst_ic2  input  IW  returned instruction.
REQ-008 The block SHALL have port ifu_pc_ic2  input  IW  PC of the returned instruction.
REQ-009 The block SHALL have port exu_ifu_except  input  1  flush request.
REQ-010 The block SHALL have port exu_ifu_stall  input  1  decode not ready; the head entry is held.
REQ-011 The block SHALL have port ifu_exu_valid_d  output  1  head entry valid toward decode.
REQ-012 The block SHALL have port ifu_exu_inst_d  output  IW  head instruction.
REQ-013 The block SHALL have port ifu_exu_pc_d  output  IW  head PC.
REQ-014 The block SHALL have port ifu_ibuf_full  output  1  back-pressure to fetch control: do not issue a new request.
REQ-015 The block SHALL have port ifu_ibuf_ovf  output  1  sticky protocol-error flag.

Function
REQ-016 The block SHALL implement a DEPTH-entry circular FIFO with read and write pointers of log2(DEPTH) bits that wrap modulo DEPTH, plus a count of log2(DEPTH)+1 bits.
REQ-017 A pop SHALL occur when ifu_exu_valid_d=1, exu_ifu_stall=0 and exu_ifu_except=0.
REQ-018 A push SHALL occur when icu_ifu_data_valid_ic2=1, drop_q=0, exu_ifu_except=0 and count<DEPTH.
REQ-019 Pushed data SHALL become visible at ifu_exu_*_d on the cycle after the push (1-cycle latency), unless REQ-034 applies.
REQ-020 A simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-021 ifu_exu_valid_d SHALL equal (count!=0); ifu_exu_inst_d and ifu_exu_pc_d SHALL show the entry at the read pointer; their values are don't-care while valid=0.
REQ-022 The block SHALL keep an inflight_q flag: set on icu_ifu_ack_ic1, cleared on icu_ifu_data_valid_ic2; if both are high in the same cycle, inflight_q SHALL be 1.
REQ-023 ifu_ibuf_full SHALL be combinational and equal to (count + inflight_q) >= DEPTH-1, so that an issued request always has a free slot.
REQ-024 On exu_ifu_except=1 the block SHALL, at the next edge, empty the FIFO (count=0, read pointer=write pointer), and SHALL NOT perform the push or pop for that cycle.
REQ-025 On exu_ifu_except=1, drop_q SHALL be set if inflight_q=1 and icu_ifu_data_valid_ic2=0, or if icu_ifu_ack_ic1=1.
REQ-026 While drop_q=1, returning data SHALL be discarded, and drop_q SHALL clear on that icu_ifu_data_valid_ic2.
REQ-027 Data returning in the same cycle as exu_ifu_except SHALL be discarded.
REQ-028 A push attempt with count==DEPTH SHALL discard the data, leave the FIFO unchanged, and set ifu_ibuf_ovf=1 until reset.
REQ-029 exu_ifu_stall SHALL have no effect on push or on flush.

Reset
REQ-030 While reset=1 at an edge, the block SHALL clear count, both pointers, inflight_q, drop_q and ifu_ibuf_ovf to 0; FIFO data SHALL NOT be reset.
REQ-031 After reset: ifu_exu_valid_d=0, ifu_ibuf_full=0, ifu_ibuf_ovf=0.
REQ-032 Reset SHALL take priority over every other input in the same cycle; an in-flight fetch interrupted by reset SHALL NOT be tracked afterwards.

Configuration
REQ-033 The block SHALL honour the macro C7BIFU_IBUF_BYPASS_EN.
REQ-034 With C7BIFU_IBUF_BYPASS_EN defined: when count==0, drop_q=0, exu_ifu_except=0 and icu_ifu_data_valid_ic2=1, the returned data SHALL drive ifu_exu_*_d combinationally with valid=1 in the same cycle. It SHALL be written to the FIFO only if exu_ifu_stall=1.
REQ-035 Without C7BIFU_IBUF_BYPASS_EN, the block SHALL have no combinational path from icu_ifu_* to ifu_exu_*; latency SHALL be exactly 1 cycle.

Verification
REQ-036 Bench SHALL cover: after reset, ack at cycle 1, data_valid with inst=0x00000013, pc=0x1C000000 at cycle 3, stall=0 -> valid=1 at cycle 4 with that inst/pc, valid=0 at cycle 5 (at cycle 3 with bypass).
REQ-037 Bench SHALL cover: stall held high, fetches pushed until full rises -> with DEPTH=4, full=1 once count=3 or count=2 with a fetch in flight; releasing stall pops in order with no loss.
REQ-038 Bench SHALL cover: ack, then except 1 cycle later, data returns 2 cycles after that -> data discarded, valid stays 0, drop_q clears, the next fetch is accepted normally.
REQ-039 Bench SHALL cover: except together with data_valid while count=2 -> count=0 next cycle, the returned data is not enqueued.
REQ-040 Bench SHALL cover: count=4 with data_valid forced -> FIFO contents unchanged, ifu_ibuf_ovf=1 and stays 1 until reset.
REQ-041 Bench SHALL cover: simultaneous push and pop at count=1 across pointer wrap (write pointer 3->0) -> count stays 1, order preserved.
